// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the
// LEGv8 datapath (slave): instruction and ALU flags in, per-state controls out.
`timescale 1ns/1ps
interface multicycle_ctrl_if #(
  parameter int ALUOPW = 3
);
  logic [31:0]       instruction;
  logic              zero;
  logic              negative;
  logic              overflow;
  logic              carry_out;
  logic              mem_ready;

  logic              PCWrite;
  logic              IRWrite;
  logic              Reg2Loc;
  logic              ALUSrc;
  logic              MemToReg;
  logic              RegWrite;
  logic              MemWrite;
  logic              MemRead;
  logic              BrTaken;
  logic              UncondBr;
  logic              ShiftSel;
  logic [ALUOPW-1:0] ALUOp;
  logic [3:0]        flags;
  logic [2:0]        state;
  logic              illegal;

  modport master (
    input  instruction, zero, negative, overflow, carry_out, mem_ready,
    output PCWrite, IRWrite, Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite,
           MemRead, BrTaken, UncondBr, ShiftSel, ALUOp, flags, state, illegal
  );

  modport slave (
    output instruction, zero, negative, overflow, carry_out, mem_ready,
    input  PCWrite, IRWrite, Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite,
           MemRead, BrTaken, UncondBr, ShiftSel, ALUOp, flags, state, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8-subset sequencer: FETCH/DECODE/EXEC/MEM/WB with a stored
// NZVC register and a sticky illegal-opcode halt. Controls decode from state + latched opcode.
`timescale 1ns/1ps
module multicycle_ctrl #(
  parameter int OPW    = 11,
  parameter int ALUOPW = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ADDI, C_ADDS, C_SUBS, C_AND, C_EOR, C_LSR,
    C_LDUR, C_STUR, C_B, C_CBZ, C_BLT, C_ILL
  } op_class_t;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_BLT  = 8'b01010100;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [ALUOPW-1:0] ALU_PASSB = 3'b000;
  localparam logic [ALUOPW-1:0] ALU_ADD   = 3'b010;
  localparam logic [ALUOPW-1:0] ALU_SUB   = 3'b011;
  localparam logic [ALUOPW-1:0] ALU_AND   = 3'b100;
  localparam logic [ALUOPW-1:0] ALU_XOR   = 3'b110;

  state_t            st;
  logic [OPW-1:0]    op;
  logic [3:0]        flags_q;
  logic              illegal_q;
  op_class_t         cls;
  logic              is_rtype;
  logic              is_branch;
  logic              is_mem;
  logic              sel_alu_src;
  logic              sel_shift;
  logic [ALUOPW-1:0] sel_alu_op;

  // Only the opcode field is ever consumed; the operand fields belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction[31-OPW:0];

  // Branch and immediate formats are matched on their shorter opcode prefixes first.
  always_comb begin
    if (op[OPW-1 -: 6] == OP_B)            cls = C_B;
    else if (op[OPW-1 -: 8] == OP_CBZ)     cls = C_CBZ;
    else if (op[OPW-1 -: 8] == OP_BLT)     cls = C_BLT;
    else if (op[OPW-1 -: 10] == OP_ADDI)   cls = C_ADDI;
    else begin
      case (op)
        OP_ADDS: cls = C_ADDS;
        OP_SUBS: cls = C_SUBS;
        OP_AND:  cls = C_AND;
        OP_EOR:  cls = C_EOR;
        OP_LSR:  cls = C_LSR;
        OP_LDUR: cls = C_LDUR;
        OP_STUR: cls = C_STUR;
        default: cls = C_ILL;
      endcase
    end
  end

  assign is_rtype  = (cls == C_ADDS) || (cls == C_SUBS) || (cls == C_AND) ||
                     (cls == C_EOR)  || (cls == C_LSR);
  assign is_branch = (cls == C_B) || (cls == C_CBZ) || (cls == C_BLT);
  assign is_mem    = (cls == C_LDUR) || (cls == C_STUR);

  // Datapath selects shared by EXEC and WB of non-branch instructions.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    sel_alu_src = 1'b0;
    sel_shift   = 1'b0;
    sel_alu_op  = ALU_PASSB;
    case (cls)
      C_ADDI, C_LDUR, C_STUR: begin
        sel_alu_src = 1'b1;
        sel_alu_op  = ALU_ADD;
      end
      C_ADDS:  sel_alu_op = ALU_ADD;
      C_SUBS:  sel_alu_op = ALU_SUB;
      C_AND:   sel_alu_op = ALU_AND;
      C_EOR:   sel_alu_op = ALU_XOR;
      C_LSR:   sel_shift  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= S_FETCH;
      op        <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      case (st)
        S_FETCH: begin
          op <= bus.instruction[31 -: OPW];
          st <= S_DECODE;
        end
        S_DECODE: begin
          if (cls == C_ILL) begin
            illegal_q <= 1'b1;
            st        <= S_HALT;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if ((cls == C_ADDS) || (cls == C_SUBS))
            flags_q <= {bus.negative, bus.zero, bus.overflow, bus.carry_out};
          if (is_branch)   st <= S_FETCH;
          else if (is_mem) st <= S_MEM;
          else             st <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) st <= (cls == C_LDUR) ? S_WB : S_FETCH;
        end
        S_WB:    st <= S_FETCH;
        S_HALT:  st <= S_HALT;
        default: st <= S_HALT;
      endcase
    end
  end

  assign bus.flags   = flags_q;
  assign bus.state   = st;
  assign bus.illegal = illegal_q;

  // Controls are forced low while reset is held, even though the state reads FETCH.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.Reg2Loc  = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemToReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.BrTaken  = 1'b0;
    bus.UncondBr = 1'b0;
    bus.ShiftSel = 1'b0;
    bus.ALUOp    = ALU_PASSB;
    if (reset_n) begin
      case (st)
        S_FETCH:  bus.IRWrite = 1'b1;
        S_DECODE: bus.Reg2Loc = is_rtype;
        S_EXEC: begin
          if (is_branch) begin
            bus.PCWrite  = 1'b1;
            bus.UncondBr = (cls == C_B);
            bus.BrTaken  = (cls == C_B) ||
                           ((cls == C_CBZ) && bus.zero) ||
                           ((cls == C_BLT) && (flags_q[3] ^ flags_q[1]));
          end else begin
            bus.Reg2Loc  = is_rtype;
            bus.ALUSrc   = sel_alu_src;
            bus.ALUOp    = sel_alu_op;
            bus.ShiftSel = sel_shift;
          end
        end
        S_MEM: begin
          bus.ALUSrc   = 1'b1;
          bus.ALUOp    = ALU_ADD;
          bus.MemRead  = (cls == C_LDUR);
          bus.MemWrite = (cls == C_STUR);
          bus.PCWrite  = (cls == C_STUR) && bus.mem_ready;
        end
        S_WB: begin
          bus.Reg2Loc  = is_rtype;
          bus.ALUSrc   = sel_alu_src;
          bus.ALUOp    = sel_alu_op;
          bus.ShiftSel = sel_shift;
          bus.RegWrite = 1'b1;
          bus.PCWrite  = 1'b1;
          bus.MemToReg = (cls == C_LDUR);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction schedule model of the
// expected control word every cycle, directed scenarios with literal expectations, random mix.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  typedef enum logic [3:0] {
    K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSR,
    K_LDUR, K_STUR, K_B, K_CBZ, K_BLT, K_ILL
  } kind_t;

  typedef enum logic [2:0] {
    P_F = 3'd0, P_D = 3'd1, P_E = 3'd2, P_M = 3'd3, P_W = 3'd4, P_H = 3'd5
  } phase_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg2loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       br_taken;
    logic       uncond_br;
    logic       shift_sel;
    logic [2:0] alu_op;
  } ctrl_t;

  logic clk;
  logic reset_n;
  multicycle_ctrl_if #(.ALUOPW(3)) bus ();

  multicycle_ctrl #(.OPW(11), .ALUOPW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ctrl_t      dut_ctrl;
  ctrl_t      exp_ctrl;
  logic [2:0] exp_state;
  logic [3:0] exp_flags;
  logic       exp_ill;
  bit         chk_en = 1'b0;

  logic [3:0] m_flags = 4'b0;
  logic       m_ill   = 1'b0;

  ctrl_t      obs_ctrl  [1:16];
  logic [2:0] obs_state [1:16];

  always_comb dut_ctrl = {bus.PCWrite, bus.IRWrite, bus.Reg2Loc, bus.ALUSrc,
                          bus.MemToReg, bus.RegWrite, bus.MemWrite, bus.MemRead,
                          bus.BrTaken, bus.UncondBr, bus.ShiftSel, bus.ALUOp};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl",    32'(dut_ctrl),  32'(exp_ctrl));
      check("state",   32'(bus.state), 32'(exp_state));
      check("flags",   32'(bus.flags), 32'(exp_flags));
      check("illegal", 32'(bus.illegal), 32'(exp_ill));
    end
  end

  function automatic logic [31:0] make_instr(input kind_t k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADDI:  make_instr = {10'b1001000100, r[21:0]};
      K_ADDS:  make_instr = {11'b10101011000, r[20:0]};
      K_SUBS:  make_instr = {11'b11101011000, r[20:0]};
      K_AND:   make_instr = {11'b10001010000, r[20:0]};
      K_EOR:   make_instr = {11'b11001010000, r[20:0]};
      K_LSR:   make_instr = {11'b11010011010, r[20:0]};
      K_LDUR:  make_instr = {11'b11111000010, r[20:0]};
      K_STUR:  make_instr = {11'b11111000000, r[20:0]};
      K_B:     make_instr = {6'b000101, r[25:0]};
      K_CBZ:   make_instr = {8'b10110100, r[23:0]};
      K_BLT:   make_instr = {8'b01010100, r[23:0]};
      default: make_instr = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit is_br(input kind_t k);
    return (k == K_B) || (k == K_CBZ) || (k == K_BLT);
  endfunction

  // Cycle c (1-based) of an instruction with w memory wait cycles.
  function automatic phase_t phase_of(input kind_t k, input int c, input int w);
    if (c == 1) return P_F;
    if (c == 2) return P_D;
    if (c == 3) return P_E;
    if ((k == K_LDUR || k == K_STUR) && c <= 4 + w) return P_M;
    return P_W;
  endfunction

  function automatic ctrl_t model_ctrl(input kind_t k, input phase_t p, input logic z,
                                       input logic rdy, input logic [3:0] fl);
    ctrl_t      c;
    logic       rt;
    logic [2:0] op;
    c  = '0;
    rt = (k == K_ADDS) || (k == K_SUBS) || (k == K_AND) || (k == K_EOR) || (k == K_LSR);
    case (k)
      K_ADDI, K_ADDS, K_LDUR, K_STUR: op = 3'b010;
      K_SUBS:  op = 3'b011;
      K_AND:   op = 3'b100;
      K_EOR:   op = 3'b110;
      default: op = 3'b000;
    endcase
    case (p)
      P_F: c.ir_write = 1'b1;
      P_D: c.reg2loc  = rt;
      P_E, P_W: begin
        if (is_br(k)) begin
          c.pc_write  = 1'b1;
          c.uncond_br = (k == K_B);
          c.br_taken  = (k == K_B) ? 1'b1 : (k == K_CBZ) ? z : (fl[3] ^ fl[1]);
        end else begin
          c.reg2loc   = rt;
          c.alu_src   = (k == K_ADDI) || (k == K_LDUR) || (k == K_STUR);
          c.alu_op    = op;
          c.shift_sel = (k == K_LSR);
          if (p == P_W) begin
            c.reg_write  = 1'b1;
            c.pc_write   = 1'b1;
            c.mem_to_reg = (k == K_LDUR);
          end
        end
      end
      P_M: begin
        c.alu_src   = 1'b1;
        c.alu_op    = 3'b010;
        c.mem_read  = (k == K_LDUR);
        c.mem_write = (k == K_STUR);
        c.pc_write  = (k == K_STUR) && rdy;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Entered and left #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input kind_t k, input logic [3:0] nzvc_in, input int w, input bit rnd);
    int         n;
    logic [3:0] nzvc;
    logic       rdy;
    phase_t     p;
    n = is_br(k) ? 3 : (k == K_LDUR) ? 5 + w : (k == K_STUR) ? 4 + w : 4;
    for (int c = 1; c <= n; c++) begin
      p    = phase_of(k, c, w);
      nzvc = rnd ? 4'($urandom) : nzvc_in;
      rdy  = (p == P_M) ? (c == 4 + w) : (rnd ? 1'($urandom) : 1'b0);
      bus.instruction = (c == 1) ? make_instr(k) : (rnd ? $urandom : 32'h0);
      {bus.negative, bus.zero, bus.overflow, bus.carry_out} = nzvc;
      bus.mem_ready = rdy;
      exp_ctrl  = model_ctrl(k, p, nzvc[2], rdy, m_flags);
      exp_state = 3'(p);
      exp_flags = m_flags;
      exp_ill   = m_ill;
      chk_en    = 1'b1;
      @(negedge clk);
      obs_ctrl[c]  = dut_ctrl;
      obs_state[c] = bus.state;
      @(posedge clk);
      #1;
      if (p == P_E && (k == K_ADDS || k == K_SUBS)) m_flags = nzvc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  v4;
    logic [23:0] seq;

    reset_n = 1'b0;
    bus.instruction = 32'h0;
    {bus.negative, bus.zero, bus.overflow, bus.carry_out} = 4'b0;
    bus.mem_ready = 1'b0;

    #3;
    check("reset_ctrl",    32'(dut_ctrl), 32'h0);
    check("reset_state",   32'(bus.state), 32'h0);
    check("reset_flags",   32'(bus.flags), 32'h0);
    check("reset_illegal", 32'(bus.illegal), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // ADDI: PC written only in the fourth cycle, WB writes the register with immediate B.
    run_instr(K_ADDI, 4'b0000, 0, 1'b0);
    for (int i = 1; i <= 4; i++) v4[i-1] = obs_ctrl[i].pc_write;
    check("addi_pcwrite_cycles", 32'(v4), 32'h8);
    check("addi_wb_regwrite_alusrc", 32'({obs_ctrl[4].reg_write, obs_ctrl[4].alu_src}), 32'h3);

    run_instr(K_ADDS, 4'b1000, 0, 1'b0);
    check("adds_flags", 32'(bus.flags), 32'h8);

    // SUBS then B.LT: branch decision comes from the freshly stored flags.
    run_instr(K_SUBS, 4'b0010, 0, 1'b0);
    run_instr(K_BLT,  4'b0000, 0, 1'b0);
    check("blt_taken",  32'({obs_ctrl[3].br_taken, obs_ctrl[3].pc_write}), 32'h3);
    run_instr(K_SUBS, 4'b1010, 0, 1'b0);
    run_instr(K_BLT,  4'b0000, 0, 1'b0);
    check("blt_not_taken", 32'({obs_ctrl[3].br_taken, obs_ctrl[3].pc_write}), 32'h1);

    // LDUR with three not-ready cycles: eight cycles in total.
    run_instr(K_LDUR, 4'b0000, 3, 1'b0);
    seq = '0;
    for (int i = 1; i <= 8; i++) seq = {seq[20:0], obs_state[i]};
    check("ldur_state_seq", 32'(seq), 32'h0536DC);
    for (int i = 4; i <= 7; i++) v4[i-4] = obs_ctrl[i].mem_read;
    check("ldur_memread_held", 32'(v4), 32'hF);
    check("ldur_wb_memtoreg", 32'(obs_ctrl[8].mem_to_reg), 32'h1);
    check("ldur_back_to_fetch", 32'(bus.state), 32'h0);

    run_instr(K_CBZ, 4'b0100, 0, 1'b0);
    check("cbz_br_unc", 32'({obs_ctrl[3].br_taken, obs_ctrl[3].uncond_br}), 32'h2);
    run_instr(K_B, 4'b0000, 0, 1'b0);
    check("b_br_unc", 32'({obs_ctrl[3].br_taken, obs_ctrl[3].uncond_br}), 32'h3);

    // Reset asserted mid-MEM of a stalled STUR: MemWrite must drop immediately.
    chk_en = 1'b0;
    bus.instruction = {11'b11111000000, 21'h0};
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stur_in_mem", 32'({bus.state, bus.MemWrite}), 32'({3'd3, 1'b1}));
    #2 reset_n = 1'b0;
    #1;
    check("stur_reset_memwrite", 32'(bus.MemWrite), 32'h0);
    check("stur_reset_ctrl", 32'(dut_ctrl), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_flags = 4'b0;
    check("post_reset_state_flags", 32'({bus.state, bus.flags}), 32'h0);

    // Random instruction mix, every live input randomized each cycle.
    for (int i = 0; i < 300; i++)
      run_instr(kind_t'($urandom_range(0, 10)), 4'b0, int'($urandom_range(0, 3)), 1'b1);

    // Illegal opcode halts until reset, regardless of later instructions.
    bus.instruction = 32'hFFFF_FFFF;
    bus.mem_ready = 1'b0;
    exp_ctrl = model_ctrl(K_ILL, P_F, 1'b0, 1'b0, m_flags);
    exp_state = 3'd0; exp_flags = m_flags; exp_ill = 1'b0; chk_en = 1'b1;
    @(posedge clk); #1;
    exp_ctrl = model_ctrl(K_ILL, P_D, 1'b0, 1'b0, m_flags);
    exp_state = 3'd1;
    @(posedge clk); #1;
    m_ill = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.instruction = make_instr(kind_t'($urandom_range(0, 10)));
      {bus.negative, bus.zero, bus.overflow, bus.carry_out} = 4'($urandom);
      bus.mem_ready = 1'($urandom);
      exp_ctrl = model_ctrl(K_ILL, P_H, 1'b0, 1'b0, m_flags);
      exp_state = 3'd5; exp_ill = m_ill;
      @(posedge clk); #1;
    end
    check("halt_sticky", 32'({bus.illegal, bus.state}), 32'({1'b1, 3'd5}));
    chk_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("halt_reset", 32'({bus.illegal, bus.state, bus.flags}), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_ill = 1'b0;
    m_flags = 4'b0;
    run_instr(K_ADDI, 4'b0, 0, 1'b1);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
